sprite_loader: RTL and testbench
================================

Name: sprite_loader

Overview:
- Writer end of the tank sprite RAM. Accepts a byte stream, for example from the UART bridge or the debug host.
- Parses a framed sprite upload and writes 12-bit pixels into the write port of the sprite RAM.
- Uses the same layout the icon renderer reads: 8 frame rows (orientations) by 3 frame columns (animation phases), each SPRITE_COLS x SPRITE_ROWS.
- Allows sprites to be replaced at run time without re-synthesising the .mem init file.

Parameters:
- SPRITE_COLS, 34: pixels per sprite row.
- SPRITE_ROWS, 34: rows per sprite.
- ADDR_W, 15: RAM address width. Must cover 8*SPRITE_ROWS*3*SPRITE_COLS = 27744.
- SYNC_BYTE, 8'hA5: start-of-upload marker.
- TIMEOUT, 1_000_000: maximum idle clocks between bytes inside an upload before it is aborted.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  byte available
- in_data  in  8  byte value
- in_ready  out  1  loader accepts byte this cycle
- wr_en  out  1  RAM write strobe
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  12  pixel value (12'h000 = transparent, written verbatim)
- busy  out  1  upload in progress (state not IDLE)
- done  out  1  one-cycle pulse after last pixel write
- err  out  1  one-cycle pulse on protocol error or timeout

Behaviour:
- Derived constants:
  - MEM_COLS = 3*SPRITE_COLS
  - FRAME_ROW_SIZE = MEM_COLS*SPRITE_ROWS
  - NPIX = SPRITE_COLS*SPRITE_ROWS
- Handshake: a byte transfers when in_valid && in_ready. in_ready = 1 in IDLE, HDR, PIX_HI, PIX_LO; 0 in FINISH.
- Reset values: state IDLE; in_ready 1; wr_en 0, wr_addr 0, wr_data 0; busy 0, done 0, err 0; all counters 0.
- Upload format: SYNC_BYTE, header byte, then NPIX pixels in raster order (x fastest, then y). Each pixel is 2 bytes: high byte (bits [3:0] = pixel[11:8], bits [7:4] must be 0), then low byte (pixel[7:0]).
- Header byte: [6:4] = frame_row 0..7, [1:0] = frame_col 0..2. Bits 7, 3, 2 must be 0.
- States:
  - IDLE: non-SYNC bytes are discarded silently. SYNC_BYTE -> HDR.
  - HDR: valid header -> latch base = frame_row*FRAME_ROW_SIZE + frame_col*SPRITE_COLS; x=0, y=0; -> PIX_HI. frame_col==3 or any reserved bit set -> err pulse, -> IDLE.
  - PIX_HI: latch nibble -> PIX_LO. Upper nibble nonzero -> err pulse, -> IDLE.
  - PIX_LO: on accept, next cycle wr_en=1, wr_data={nibble,in_data}, wr_addr=base + y*MEM_COLS + x. Then advance the counters:
    - x<SPRITE_COLS-1: x++.
    - otherwise x=0, y++ (row_base += MEM_COLS; multiplier only allowed for base).
    - Last pixel (x=SPRITE_COLS-1, y=SPRITE_ROWS-1) -> FINISH; otherwise -> PIX_HI.
  - FINISH: one cycle. done=1 (coincides with the cycle after the last wr_en). -> IDLE.
- Write latency: wr_en is high exactly 1 clock after the PIX_LO handshake, for 1 cycle. wr_addr/wr_data hold their value otherwise.
- Timeout: idle counter clears on every accepted byte and runs only in HDR/PIX_HI/PIX_LO. Reaching TIMEOUT -> err pulse, -> IDLE. Pixels already written stay in RAM; no rollback.
- SYNC_BYTE inside pixel data is data, not a restart.
- Reset mid-upload: immediate return to IDLE. No wr_en in the cycle after reset, even if a PIX_LO accept coincided with reset.
- done and err are never asserted in the same cycle.
- The read side (renderer) is unaffected: it uses the other RAM port. Pixel tearing during an upload is acceptable.

Decomposition:
- Shared package sprite_pkg holds the sprite geometry constants (SPRITE_COLS, SPRITE_ROWS, MEM_COLS, FRAME_ROW_SIZE, NPIX) and the orientation-to-frame_row map (N=1, NE=7, E=3, SE=5, S=0, SW=4, W=2, NW=6). The renderer and loader both import it.
- The state enum (IDLE, HDR, PIX_HI, PIX_LO, FINISH) is local.
- The RAM becomes a dual-port sprite_ram (port A write from this block, port B read). This block contains no RAM.
- No sub-module inside sprite_loader.

Test Plan:
- Full upload, header 8'h31 (row 3, col 1), pixel k = k[11:0]:
  - 1156 wr_en pulses.
  - First wr_addr = 3*3468+34 = 10438; pixel x=0,y=1 at 10540; last at 10438+33*102+33 = 13837.
  - done 1 cycle after the last write; err never set.
- Garbage 8'h00, 8'hFF, then SYNC, header 8'h00, 2 pixels 12'hABC, 12'h000 (transparent):
  - Writes at addresses 0 and 1 with data 12'hABC and 12'h000.
  - busy stays 1.
- Header 8'h03 (col 3) -> err pulse next cycle, state IDLE, no writes. Repeat with header 8'h80 -> same.
- Pixel high byte 8'h1F -> err, IDLE, no write for that pixel; prior pixels remain written.
- Stall after 10 pixels with TIMEOUT=100 -> err exactly when the idle counter reaches 100, busy falls. A following fresh upload to row 7, col 2 completes normally.
- Assert reset in the same cycle as a PIX_LO accept -> no wr_en afterwards; busy=0, in_ready=1.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared tank sprite geometry and the orientation-to-frame_row map.
// Both the icon renderer and the sprite loader import this package.
package sprite_pkg;

    localparam int SPRITE_COLS    = 34;
    localparam int SPRITE_ROWS    = 34;
    localparam int FRAME_ROWS     = 8;
    localparam int FRAME_COLS     = 3;
    localparam int MEM_COLS       = FRAME_COLS * SPRITE_COLS;
    localparam int FRAME_ROW_SIZE = MEM_COLS * SPRITE_ROWS;
    localparam int NPIX           = SPRITE_COLS * SPRITE_ROWS;
    localparam int MEM_WORDS      = FRAME_ROWS * FRAME_ROW_SIZE;

    typedef enum logic [2:0] {
        DIR_N, DIR_NE, DIR_E, DIR_SE, DIR_S, DIR_SW, DIR_W, DIR_NW
    } orient_e;

    // Upload header byte; the reserved fields must read as zero.
    typedef struct packed {
        logic       rsv_hi;
        logic [2:0] frame_row;
        logic [1:0] rsv_lo;
        logic [1:0] frame_col;
    } sprite_hdr_t;

    function automatic logic [2:0] frame_row_of(input orient_e dir);
        case (dir)
            DIR_N:   return 3'd1;
            DIR_NE:  return 3'd7;
            DIR_E:   return 3'd3;
            DIR_SE:  return 3'd5;
            DIR_S:   return 3'd0;
            DIR_SW:  return 3'd4;
            DIR_W:   return 3'd2;
            default: return 3'd6;
        endcase
    endfunction

endpackage

// File: rtl/sprite_loader.sv
// Writer side of the dual-port sprite RAM: parses a framed byte upload
// (SYNC, header, 12-bit pixels as hi/lo byte pairs) into port-A writes.
module sprite_loader #(
    parameter int         SPRITE_COLS = sprite_pkg::SPRITE_COLS,
    parameter int         SPRITE_ROWS = sprite_pkg::SPRITE_ROWS,
    parameter int         ADDR_W      = 15,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT     = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import sprite_pkg::*;

    localparam int ROW_STRIDE   = 3 * SPRITE_COLS;
    localparam int FRAME_STRIDE = ROW_STRIDE * SPRITE_ROWS;
    localparam int X_W          = $clog2(SPRITE_COLS);
    localparam int Y_W          = $clog2(SPRITE_ROWS);
    localparam int T_W          = $clog2(TIMEOUT + 1);

    localparam logic [X_W-1:0]    X_LAST        = X_W'(SPRITE_COLS - 1);
    localparam logic [Y_W-1:0]    Y_LAST        = Y_W'(SPRITE_ROWS - 1);
    localparam logic [T_W-1:0]    IDLE_LIMIT    = T_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE_A  = ADDR_W'(ROW_STRIDE);
    localparam logic [ADDR_W-1:0] FRAME_STRIDE_A = ADDR_W'(FRAME_STRIDE);
    localparam logic [ADDR_W-1:0] COL_STRIDE_A  = ADDR_W'(SPRITE_COLS);

    typedef enum logic [2:0] {IDLE, HDR, PIX_HI, PIX_LO, FINISH} state_e;

    state_e            state, state_nx;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] row_base;
    logic [3:0]        nibble;
    logic [T_W-1:0]    idle_cnt;

    sprite_hdr_t       hdr;
    logic              accept;
    logic              active;
    logic              hdr_ok;
    logic              last_pix;
    logic              timed_out;
    logic [ADDR_W-1:0] hdr_base;

    logic              load_hdr;
    logic              load_nibble;
    logic              write_nx;
    logic              done_nx;
    logic              err_nx;

    assign hdr       = sprite_hdr_t'(in_data);
    assign in_ready  = (state != FINISH);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign active    = (state == HDR) || (state == PIX_HI) || (state == PIX_LO);
    assign hdr_ok    = !hdr.rsv_hi && (hdr.rsv_lo == 2'b00) && (hdr.frame_col != 2'd3);
    assign last_pix  = (x == X_LAST) && (y == Y_LAST);
    assign timed_out = active && !accept && (idle_cnt == IDLE_LIMIT);

    // The only multiplier: sprite origin from the header, once per upload.
    assign hdr_base = FRAME_STRIDE_A * ADDR_W'(hdr.frame_row)
                    + COL_STRIDE_A * ADDR_W'(hdr.frame_col);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // NOTE: every signal driven here gets a default before the case statement;
    // a branch that forgets one would otherwise infer a latch.
    always_comb begin
        state_nx    = state;
        load_hdr    = 1'b0;
        load_nibble = 1'b0;
        write_nx    = 1'b0;
        done_nx     = 1'b0;
        err_nx      = 1'b0;
        case (state)
            IDLE: begin
                if (accept && in_data == SYNC_BYTE) state_nx = HDR;
            end
            HDR: begin
                if (accept) begin
                    if (hdr_ok) begin
                        load_hdr = 1'b1;
                        state_nx = PIX_HI;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = IDLE;
                    end
                end else if (timed_out) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end
            end
            PIX_HI: begin
                if (accept) begin
                    if (in_data[7:4] == 4'h0) begin
                        load_nibble = 1'b1;
                        state_nx    = PIX_LO;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = IDLE;
                    end
                end else if (timed_out) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end
            end
            PIX_LO: begin
                if (accept) begin
                    write_nx = 1'b1;
                    state_nx = last_pix ? FINISH : PIX_HI;
                end else if (timed_out) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end
            end
            FINISH: begin
                done_nx  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            x        <= '0;
            y        <= '0;
            row_base <= '0;
            nibble   <= '0;
            idle_cnt <= '0;
        end else begin
            wr_en <= write_nx;
            done  <= done_nx;
            err   <= err_nx;

            if (accept || !active || timed_out) idle_cnt <= '0;
            else                                idle_cnt <= idle_cnt + 1'b1;

            if (load_hdr) begin
                row_base <= hdr_base;
                x        <= '0;
                y        <= '0;
            end

            if (load_nibble) nibble <= in_data[3:0];

            if (write_nx) begin
                wr_addr <= row_base + ADDR_W'(x);
                wr_data <= {nibble, in_data};
                if (x != X_LAST) begin
                    x <= x + 1'b1;
                end else begin
                    x        <= '0;
                    y        <= y + 1'b1;
                    row_base <= row_base + ROW_STRIDE_A;
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_loader.sv
// Randomized bench for sprite_loader: a write-address model built from the
// sprite layout arithmetic is compared against every observed RAM write.
module tb_sprite_loader;

    localparam int SC       = 34;
    localparam int SR       = 34;
    localparam int MC       = 3 * SC;
    localparam int FRS      = MC * SR;
    localparam int NP       = SC * SR;
    localparam int TMO      = 100;
    localparam int AW       = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_acc = 0;

    int obs_addr[$];
    int obs_data[$];
    int obs_cyc[$];
    int done_cyc[$];
    int err_cyc[$];
    int exp_addr[$];
    int exp_data[$];

    sprite_loader #(
        .SPRITE_COLS(SC), .SPRITE_ROWS(SR), .ADDR_W(AW),
        .SYNC_BYTE(8'hA5), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, expv, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en) begin
                obs_addr.push_back(int'(wr_addr));
                obs_data.push_back(int'(wr_data));
                obs_cyc.push_back(cyc);
            end
            if (done) done_cyc.push_back(cyc);
            if (err)  err_cyc.push_back(cyc);
            if (done || err) check("done_err_exclusive", int'(done && err), 0);
        end
    end

    task automatic clear_all();
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
        done_cyc.delete(); err_cyc.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        bit taken = 0;
        idle_cycles(int'($urandom_range(max_gap, 0)));
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 20 && !taken; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                last_acc = cyc;
                taken = 1;
            end
        end
        in_valid = 1'b0;
        if (!taken) check("handshake_timeout", 0, 1);
    endtask

    task automatic send_pixel(input logic [11:0] p);
        send_byte({4'h0, p[11:8]}, 2);
        send_byte(p[7:0], 2);
    endtask

    function automatic int pix_addr(input int row, input int col, input int k);
        return row * FRS + col * SC + (k / SC) * MC + (k % SC);
    endfunction

    task automatic send_model_pixel(input int row, input int col, input int k, input logic [11:0] p);
        exp_addr.push_back(pix_addr(row, col, k));
        exp_data.push_back(int'(p));
        send_pixel(p);
    endtask

    task automatic compare_writes(input string tag);
        int mism = 0;
        check({tag, "_count"}, obs_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            if (obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data[i]) begin
                if (mism == 0)
                    $display("  first difference at write %0d: addr %0d data %0h, model addr %0d data %0h",
                             i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
                mism++;
            end
        end
        check({tag, "_seq"}, mism, 0);
    endtask

    function automatic logic [11:0] rand_pixel(input int k);
        logic [11:0] p = 12'($urandom);
        if (k % 7 == 0) p[7:0] = 8'hA5;
        return p;
    endfunction

    initial begin
        #900_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] h;
        int row, col, n;

        idle_cycles(3);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done_err", {done, err}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle_cycles(2);

        // Full upload to row 3, col 1 with pixel k = k[11:0].
        clear_all();
        send_byte(8'hA5, 2);
        send_byte(8'h31, 2);
        for (int k = 0; k < NP; k++) send_model_pixel(3, 1, k, 12'(k));
        idle_cycles(5);
        compare_writes("full");
        if (obs_addr.size() == NP) begin
            check("full_first_addr", obs_addr[0], 10438);
            check("full_x0y1_addr", obs_addr[SC], 10540);
            check("full_last_addr", obs_addr[NP-1], 13837);
        end
        check("full_done_count", done_cyc.size(), 1);
        if (done_cyc.size() == 1 && obs_cyc.size() > 0)
            check("full_done_latency", done_cyc[0] - obs_cyc[obs_cyc.size()-1], 1);
        check("full_err_count", err_cyc.size(), 0);
        check("full_busy_after", busy, 0);

        // Garbage before SYNC, then two pixels into row 0, col 0.
        clear_all();
        send_byte(8'h00, 2);
        send_byte(8'hFF, 2);
        send_byte(8'hA5, 2);
        send_byte(8'h00, 2);
        send_model_pixel(0, 0, 0, 12'hABC);
        send_model_pixel(0, 0, 1, 12'h000);
        idle_cycles(3);
        compare_writes("short");
        check("short_busy", busy, 1);
        idle_cycles(TMO + 5);
        check("short_timeout_err", err_cyc.size(), 1);
        check("short_idle_after", busy, 0);

        // Bad headers: frame_col 3, reserved bit 7, random reserved bit.
        for (int i = 0; i < 3; i++) begin
            clear_all();
            h = {1'b0, 3'($urandom_range(7, 0)), 2'b00, 2'($urandom_range(2, 0))};
            if (i == 0) h = 8'h03;
            else if (i == 1) h = 8'h80;
            else case ($urandom_range(2, 0))
                0: h[7] = 1'b1;
                1: h[3] = 1'b1;
                default: h[2] = 1'b1;
            endcase
            send_byte(8'hA5, 2);
            send_byte(h, 2);
            idle_cycles(3);
            check("badhdr_err_count", err_cyc.size(), 1);
            if (err_cyc.size() > 0) check("badhdr_err_latency", err_cyc[0] - last_acc, 0);
            check("badhdr_writes", obs_addr.size(), 0);
            check("badhdr_busy", busy, 0);
        end

        // Bad pixel high byte after a few good pixels.
        clear_all();
        row = int'($urandom_range(7, 0));
        col = int'($urandom_range(2, 0));
        n   = int'($urandom_range(8, 2));
        send_byte(8'hA5, 2);
        send_byte({1'b0, 3'(row), 2'b00, 2'(col)}, 2);
        for (int k = 0; k < n; k++) send_model_pixel(row, col, k, rand_pixel(k));
        send_byte({4'($urandom_range(15, 1)), 4'($urandom)}, 2);
        idle_cycles(3);
        compare_writes("badpix");
        check("badpix_err_count", err_cyc.size(), 1);
        if (err_cyc.size() > 0) check("badpix_err_latency", err_cyc[0] - last_acc, 0);
        check("badpix_busy", busy, 0);

        // Stall after 10 pixels until the idle timeout fires.
        clear_all();
        send_byte(8'hA5, 2);
        send_byte(8'h52, 2);
        for (int k = 0; k < 10; k++) send_model_pixel(5, 2, k, rand_pixel(k));
        for (int t = 0; t < 3 * TMO && err_cyc.size() == 0; t++) idle_cycles(1);
        compare_writes("stall");
        check("stall_err_count", err_cyc.size(), 1);
        if (err_cyc.size() > 0) check("stall_err_latency", err_cyc[0] - last_acc, TMO);
        check("stall_busy", busy, 0);

        // Fresh full upload to row 7, col 2 with random data (SYNC bytes inside).
        clear_all();
        send_byte(8'hA5, 2);
        send_byte(8'h72, 2);
        for (int k = 0; k < NP; k++) send_model_pixel(7, 2, k, rand_pixel(k));
        idle_cycles(5);
        compare_writes("full72");
        if (obs_addr.size() == NP) check("full72_last_addr", obs_addr[NP-1], 27743);
        check("full72_done_count", done_cyc.size(), 1);
        check("full72_err_count", err_cyc.size(), 0);

        // Reset coinciding with a PIX_LO accept.
        clear_all();
        send_byte(8'hA5, 2);
        send_byte(8'h10, 2);
        send_byte(8'h0A, 2);
        in_valid = 1'b1;
        in_data  = 8'h55;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        idle_cycles(4);
        check("rstmid_writes", obs_addr.size(), 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_in_ready", in_ready, 1);
        check("rstmid_done_err", done_cyc.size() + err_cyc.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
